id_stage_decoder: RTL

// Registered RV32I(+M) decode stage between IF and EX. Decodes one instruction per cycle into an
// rv32i_ctrl_word plus operand fields and immediate, then buffers it behind a valid/ready handshake.
// A 2-entry skid buffer keeps in_ready a pure register output, so EX back-pressure never forms a

---
 rtl/id_stage_decoder_pkg.sv | 84 ++++++++
 rtl/id_stage_decoder_instr_decoder.sv | 148 ++++++++++++++
 rtl/id_stage_decoder.sv | 122 ++++++++++++
 3 files changed

// File: rtl/id_stage_decoder_pkg.sv
// Shared types for the ID stage: control word, mux selects, buffer states and decode helpers.
package id_stage_decoder_pkg;

  localparam logic [6:0] OpLui   = 7'b0110111;
  localparam logic [6:0] OpAuipc = 7'b0010111;
  localparam logic [6:0] OpJal   = 7'b1101111;
  localparam logic [6:0] OpJalr  = 7'b1100111;
  localparam logic [6:0] OpBr    = 7'b1100011;
  localparam logic [6:0] OpLoad  = 7'b0000011;
  localparam logic [6:0] OpStore = 7'b0100011;
  localparam logic [6:0] OpImm   = 7'b0010011;
  localparam logic [6:0] OpReg   = 7'b0110011;
  localparam logic [6:0] OpCsr   = 7'b1110011;

  localparam logic [6:0] Funct7Base   = 7'h00;
  localparam logic [6:0] Funct7Alt    = 7'h20;
  localparam logic [6:0] Funct7Muldiv = 7'h01;

  typedef enum logic [2:0] {
    AluAdd, AluSll, AluSra, AluSub, AluXor, AluSrl, AluOr, AluAnd
  } alu_ops_t;

  typedef enum logic [2:0] {
    BrEq = 3'b000, BrNe = 3'b001, BrLt = 3'b100, BrGe = 3'b101, BrLtu = 3'b110, BrGeu = 3'b111
  } branch_funct3_t;

  typedef enum logic {Alu1Rs1Out, Alu1PcOut} alumux1_sel_t;

  typedef enum logic [2:0] {
    Alu2IImm, Alu2UImm, Alu2BImm, Alu2SImm, Alu2JImm, Alu2Rs2Out
  } alumux2_sel_t;

  typedef enum logic [3:0] {
    RfAluOut, RfBrEn, RfUImm, RfLw, RfPcPlus4, RfLb, RfLbu, RfLh, RfLhu
  } regfilemux_sel_t;

  typedef enum logic {CmpRs2Out, CmpIImm} cmpmux_sel_t;

  typedef enum logic [2:0] {
    MdMul, MdMulh, MdMulhsu, MdMulhu, MdDiv, MdDivu, MdRem, MdRemu
  } muldiv_funct3_t;

  typedef enum logic [1:0] {StEmpty, StOne, StTwo} decode_state_t;

  typedef struct packed {
    alu_ops_t        aluop;
    branch_funct3_t  cmpop;
    alumux1_sel_t    alumux1_sel;
    alumux2_sel_t    alumux2_sel;
    regfilemux_sel_t regfilemux_sel;
    cmpmux_sel_t     cmpmux_sel;
    logic            load_regfile;
    logic            mem_read;
    logic            mem_write;
    logic            br_op;
    logic            jmp_op;
    logic            muldiv_en;
    muldiv_funct3_t  muldiv_op;
    logic [3:0]      rmask;
    logic [3:0]      wmask;
  } ctrl_t;

  // Byte-lane mask for a load/store width encoded in funct3[1:0].
  function automatic logic [3:0] mask_from_funct3(logic [2:0] f3);
    case (f3[1:0])
      2'b00:   return 4'b0001;
      2'b01:   return 4'b0011;
      default: return 4'b1111;
    endcase
  endfunction

  // ALU op for the register/immediate arithmetic group; alt is instr[30].
  function automatic alu_ops_t alu_from_funct3(logic [2:0] f3, logic alt);
    case (f3)
      3'b001:  return AluSll;
      3'b100:  return AluXor;
      3'b101:  return alt ? AluSra : AluSrl;
      3'b110:  return AluOr;
      3'b111:  return AluAnd;
      default: return AluAdd;
    endcase
  endfunction

endpackage

// File: rtl/id_stage_decoder_instr_decoder.sv
// Combinational RV32I(+M) decoder: raw word to control word, immediate, fields and illegal flag.
module id_stage_decoder_instr_decoder
  import id_stage_decoder_pkg::*;
#(
  parameter int unsigned Xlen   = 32,
  parameter bit          EnMext = 1'b1,
  parameter bit          EnCsr  = 1'b0
) (
  input  logic [31:0]     instr_i,
  output ctrl_t           ctrl_o,
  output logic [Xlen-1:0] imm_o,
  output logic [4:0]      rs1_o,
  output logic [4:0]      rs2_o,
  output logic [4:0]      rd_o,
  output logic            illegal_o
);

  logic [6:0]  opcode;
  logic [2:0]  funct3;
  logic [6:0]  funct7;
  logic [31:0] imm_i, imm_s, imm_b, imm_u, imm_j, imm32;

  assign opcode = instr_i[6:0];
  assign funct3 = instr_i[14:12];
  assign funct7 = instr_i[31:25];
  assign rs1_o  = instr_i[19:15];
  assign rs2_o  = instr_i[24:20];
  assign rd_o   = instr_i[11:7];

  assign imm_i = {{20{instr_i[31]}}, instr_i[31:20]};
  assign imm_s = {{20{instr_i[31]}}, instr_i[31:25], instr_i[11:7]};
  assign imm_b = {{19{instr_i[31]}}, instr_i[31], instr_i[7], instr_i[30:25], instr_i[11:8], 1'b0};
  assign imm_u = {instr_i[31:12], 12'b0};
  assign imm_j = {{11{instr_i[31]}}, instr_i[31], instr_i[19:12], instr_i[20], instr_i[30:21],
                  1'b0};

  assign imm_o = Xlen'($signed(imm32));

  // Opcode decode; an illegal result wipes the control word so the entry has no side effects.
  always_comb begin
    ctrl_o    = '0;
    illegal_o = 1'b0;
    imm32     = '0;
    case (opcode)
      OpLui: begin
        imm32                 = imm_u;
        ctrl_o.load_regfile   = 1'b1;
        ctrl_o.regfilemux_sel = RfUImm;
      end
      OpAuipc: begin
        imm32               = imm_u;
        ctrl_o.load_regfile = 1'b1;
        ctrl_o.alumux1_sel  = Alu1PcOut;
        ctrl_o.alumux2_sel  = Alu2UImm;
      end
      OpJal: begin
        imm32                 = imm_j;
        ctrl_o.load_regfile   = 1'b1;
        ctrl_o.jmp_op         = 1'b1;
        ctrl_o.alumux1_sel    = Alu1PcOut;
        ctrl_o.alumux2_sel    = Alu2JImm;
        ctrl_o.regfilemux_sel = RfPcPlus4;
      end
      OpJalr: begin
        imm32                 = imm_i;
        ctrl_o.load_regfile   = 1'b1;
        ctrl_o.jmp_op         = 1'b1;
        ctrl_o.alumux1_sel    = Alu1Rs1Out;
        ctrl_o.alumux2_sel    = Alu2IImm;
        ctrl_o.regfilemux_sel = RfPcPlus4;
      end
      OpBr: begin
        imm32              = imm_b;
        ctrl_o.br_op       = 1'b1;
        ctrl_o.cmpop       = branch_funct3_t'(funct3);
        ctrl_o.alumux1_sel = Alu1PcOut;
        ctrl_o.alumux2_sel = Alu2BImm;
        illegal_o          = (funct3[2:1] == 2'b01);
      end
      OpLoad: begin
        imm32               = imm_i;
        ctrl_o.load_regfile = 1'b1;
        ctrl_o.mem_read     = 1'b1;
        ctrl_o.rmask        = mask_from_funct3(funct3);
        case (funct3)
          3'b000:  ctrl_o.regfilemux_sel = RfLb;
          3'b001:  ctrl_o.regfilemux_sel = RfLh;
          3'b010:  ctrl_o.regfilemux_sel = RfLw;
          3'b100:  ctrl_o.regfilemux_sel = RfLbu;
          3'b101:  ctrl_o.regfilemux_sel = RfLhu;
          default: illegal_o = 1'b1;
        endcase
      end
      OpStore: begin
        imm32              = imm_s;
        ctrl_o.mem_write   = 1'b1;
        ctrl_o.alumux2_sel = Alu2SImm;
        ctrl_o.wmask       = mask_from_funct3(funct3);
        illegal_o          = (funct3 >= 3'd3);
      end
      OpImm, OpReg: begin
        ctrl_o.load_regfile = 1'b1;
        ctrl_o.aluop        = alu_from_funct3(funct3, instr_i[30]);
        if (funct3[2:1] == 2'b01) begin
          ctrl_o.cmpop          = funct3[0] ? BrLtu : BrLt;
          ctrl_o.regfilemux_sel = RfBrEn;
        end
        if (opcode == OpImm) begin
          imm32              = imm_i;
          ctrl_o.alumux2_sel = Alu2IImm;
          ctrl_o.cmpmux_sel  = CmpIImm;
          if (funct3 == 3'b001) begin
            illegal_o = (funct7 != Funct7Base);
          end else if (funct3 == 3'b101) begin
            illegal_o = (funct7 != Funct7Base) && (funct7 != Funct7Alt);
          end
        end else begin
          ctrl_o.alumux2_sel = Alu2Rs2Out;
          ctrl_o.cmpmux_sel  = CmpRs2Out;
          if (funct7 == Funct7Alt && funct3 == 3'b000) begin
            ctrl_o.aluop = AluSub;
          end else if (funct7 == Funct7Muldiv && EnMext) begin
            // M-extension ops bypass the ALU/compare paths entirely.
            ctrl_o.aluop          = AluAdd;
            ctrl_o.cmpop          = BrEq;
            ctrl_o.regfilemux_sel = RfAluOut;
            ctrl_o.muldiv_en      = 1'b1;
            ctrl_o.muldiv_op      = muldiv_funct3_t'(funct3);
          end else if (!(funct7 == Funct7Base || (funct7 == Funct7Alt && funct3 == 3'b101))) begin
            illegal_o = 1'b1;
          end
        end
      end
      OpCsr: begin
        imm32     = imm_i;
        illegal_o = !EnCsr;
      end
      default: illegal_o = 1'b1;
    endcase
    if (rd_o == 5'd0) begin
      ctrl_o.load_regfile = 1'b0;
    end
    if (illegal_o) begin
      ctrl_o = '0;
    end
  end

endmodule

// File: rtl/id_stage_decoder.sv
// Registered decode stage with a 2-entry skid buffer; in_ready comes straight from a flop.
module id_stage_decoder
  import id_stage_decoder_pkg::*;
#(
  parameter int unsigned Xlen   = 32,
  parameter bit          EnMext = 1'b1,
  parameter bit          EnCsr  = 1'b0
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            flush,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [31:0]     in_instr,
  input  logic [Xlen-1:0] in_pc,
  output logic            out_valid,
  input  logic            out_ready,
  output ctrl_t           out_ctrl,
  output logic [Xlen-1:0] out_pc,
  output logic [4:0]      out_rs1,
  output logic [4:0]      out_rs2,
  output logic [4:0]      out_rd,
  output logic [Xlen-1:0] out_imm,
  output logic            out_illegal
);

  typedef struct packed {
    ctrl_t           ctrl;
    logic [Xlen-1:0] pc;
    logic [4:0]      rs1;
    logic [4:0]      rs2;
    logic [4:0]      rd;
    logic [Xlen-1:0] imm;
    logic            illegal;
  } entry_t;

  decode_state_t state_q, state_d;
  entry_t        main_q, main_d, skid_q, skid_d, dec;
  logic          in_ready_q, in_ready_d;
  logic          in_fire, out_fire;

  id_stage_decoder_instr_decoder #(
    .Xlen  (Xlen),
    .EnMext(EnMext),
    .EnCsr (EnCsr)
  ) u_instr_decoder (
    .instr_i  (in_instr),
    .ctrl_o   (dec.ctrl),
    .imm_o    (dec.imm),
    .rs1_o    (dec.rs1),
    .rs2_o    (dec.rs2),
    .rd_o     (dec.rd),
    .illegal_o(dec.illegal)
  );
  assign dec.pc = in_pc;

  assign in_fire  = in_valid && in_ready_q;
  assign out_fire = out_valid && out_ready;

  // Buffer occupancy and payload movement; flush overrides any handshake.
  always_comb begin
    state_d = state_q;
    main_d  = main_q;
    skid_d  = skid_q;
    unique case (state_q)
      StEmpty: begin
        if (in_fire) begin
          main_d  = dec;
          state_d = StOne;
        end
      end
      StOne: begin
        if (in_fire && out_fire) begin
          main_d = dec;
        end else if (in_fire) begin
          skid_d  = dec;
          state_d = StTwo;
        end else if (out_fire) begin
          state_d = StEmpty;
        end
      end
      StTwo: begin
        // Skid entry is older than anything arriving, so it moves up first.
        if (out_fire) begin
          main_d  = skid_q;
          state_d = StOne;
        end
      end
      default: state_d = StEmpty;
    endcase
    if (flush) begin
      state_d = StEmpty;
    end
    in_ready_d = (state_d != StTwo);
  end

  // State, payload and registered ready; reset drops every entry.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= StEmpty;
      in_ready_q <= 1'b1;
      main_q     <= '0;
      skid_q     <= '0;
    end else begin
      state_q    <= state_d;
      in_ready_q <= in_ready_d;
      main_q     <= main_d;
      skid_q     <= skid_d;
    end
  end

  assign in_ready    = in_ready_q;
  assign out_valid   = (state_q != StEmpty);
  assign out_ctrl    = main_q.ctrl;
  assign out_pc      = main_q.pc;
  assign out_rs1     = main_q.rs1;
  assign out_rs2     = main_q.rs2;
  assign out_rd      = main_q.rd;
  assign out_imm     = main_q.imm;
  assign out_illegal = main_q.illegal;

endmodule
